// File: rtl/alu_op_sequencer.sv
// Collects A, B and fxn beats for an external combinational ALU, holds them for a settle window, then captures X.
// Latency: result valid EXEC_CYCLES edges after the fxn beat; in_ready is low from the fxn accept until the result is consumed.
module alu_op_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [2:0] alu_fxn,
  input  logic [5:0] alu_x,
  output logic [5:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_F,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       ld_a;
  logic       ld_b;
  logic       ld_f;
  logic       cap;
  logic       consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  // in_ready is a pure state decode so it never depends on in_valid or out_ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_f      = 1'b0;
    cap       = 1'b0;
    consume   = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_a      = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_b      = 1'b1;
          state_nxt = LOAD_F;
        end
      end
      LOAD_F: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_f      = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          consume   = 1'b1;
          state_nxt = LOAD_A;
        end
      end
      default: begin
        state_nxt = LOAD_A;
      end
    endcase
  end

  // Operand registers persist across transactions; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= 6'd0;
      alu_b   <= 6'd0;
      alu_fxn <= 3'd0;
    end else begin
      if (ld_a) alu_a <= in_data;
      if (ld_b) alu_b <= in_data;
      if (ld_f) alu_fxn <= in_data[2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (ld_f) begin
      cnt <= CNT_INIT;
    end else if (state == EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= 6'd0;
      out_valid <= 1'b0;
    end else if (cap) begin
      out_data  <= alu_x;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Front-end and result-capture stage wrapped around the 6-bit combinational ALU. The block accepts a transaction as three beats on a 6-bit valid/ready input stream: operand A, operand B, then the function code. It holds A, B and fxn stable on the ALU input pins for a programmable settle window, then registers the ALU result X. The result is presented on a valid/ready output stream until it is consumed.

## Interface
- EXEC_CYCLES, default 1: number of cycles the operands and function are held on the ALU before X is captured. Legal range 1–15.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_data  input  6  beat payload: A, then B, then fxn in in_data[2:0].
- in_valid  input  1  in_data holds a valid beat.
- in_ready  output  1  block accepts a beat this cycle.
- alu_a  output  6  registered operand A, drives ALU input A.
- alu_b  output  6  registered operand B, drives ALU input B.
- alu_fxn  output  3  registered function code, drives ALU input fxn.
- alu_x  input  6  ALU result X.
- out_data  output  6  registered captured result.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes out_data this cycle.

## Operation
- States: LOAD_A, LOAD_B, LOAD_F, EXEC, DONE. Reset state is LOAD_A.
- A beat is accepted on a rising edge where in_valid & in_ready = 1. in_ready = 1 exactly in LOAD_A, LOAD_B and LOAD_F. It is decoded from the state, so it reads 1 while rst is held.
- LOAD_A: on accept, alu_a <= in_data and the state goes to LOAD_B.
- LOAD_B: on accept, alu_b <= in_data and the state goes to LOAD_F.
- LOAD_F: on accept, alu_fxn <= in_data[2:0] (in_data[5:3] ignored), the settle counter is loaded with EXEC_CYCLES-1, and the state goes to EXEC.
- In any LOAD state with in_valid = 0, the state and registers hold. Idle gaps between beats are legal.
- EXEC: the counter decrements each cycle. On the edge where the counter = 0, out_data <= alu_x, out_valid <= 1, and the state goes to DONE.
- DONE: out_valid = 1 and out_data is held. On an edge with out_ready = 1, out_valid <= 0 and the state goes to LOAD_A. Otherwise everything holds, for any number of cycles.
- alu_a, alu_b and alu_fxn keep their last loaded values until overwritten by the next transaction's beats. They are never cleared except by reset.
- The block performs no arithmetic. The result is alu_x verbatim, 6 bits, no extension or flags.
- rst = 1 at any time, including mid-transaction:
  - state goes to LOAD_A immediately;
  - alu_a, alu_b, out_data go to 6'b000000; alu_fxn goes to 3'b000; out_valid goes to 0; the counter goes to 0.
  - A partially loaded transaction is discarded. The first accepted beat after reset is always operand A.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, alu_a = 0, alu_b = 0, alu_fxn = 0.
- Throughput: with no input gaps and out_ready held at 1, one transaction takes 3 + EXEC_CYCLES + 1 cycles.
- Latency, for the fxn beat accepted at edge N:
  - the state is EXEC from N through N+EXEC_CYCLES;
  - alu_x is sampled at edge N+EXEC_CYCLES;
  - out_valid is high from that edge onward.
- For EXEC_CYCLES = 1, out_valid rises one edge after the fxn beat is accepted.
- During EXEC and DONE, in_ready = 0. in_valid is ignored and no beat is lost or consumed.
- The result is accepted at edge M with out_ready = 1. in_ready is 1 in the cycle after M, so the earliest next A beat is at edge M+1. There is no same-cycle out-accept plus A-accept.
- out_ready asserted outside DONE has no effect.
- All outputs are registered or state-decoded. No combinational path exists from in_valid or out_ready to any output.

## Test plan
- Add: beats A=6'd5, B=6'd3, fxn=3'b110 back-to-back, out_ready = 1 → out_valid rises one edge after the fxn accept (EXEC_CYCLES = 1) with out_data = 6'd8. in_ready returns high the cycle after the out accept.
- Subtract plus upper-bit masking: A=6'd5, B=6'd3, in_data=6'b111111 on the fxn beat → alu_fxn = 3'b111 and out_data = 6'd2.
- Gaps and backpressure: in_valid low 2 cycles between each beat, then out_ready low 5 cycles in DONE; transaction A=6'd1, fxn=3'b010.
  - Beats are accepted only on valid cycles.
  - out_data = 6'b111111 is held stable with out_valid = 1 for all 5 cycles, and in_ready = 0 throughout.
  - The result is consumed on the first edge with out_ready = 1.
- Reset mid-operation: assert rst asynchronously after the B beat. Outputs clear without a clock edge. Then a new transaction A=6'd7, B=6'd7, fxn=3'b000 → out_data = 6'd7, proving the first post-reset beat landed in A.
- Settle window: EXEC_CYCLES = 3; alu_x changes value during the EXEC cycles → out_data equals alu_x as sampled exactly 3 edges after the fxn accept.
- Idle robustness: in_valid pulses and out_ready toggling during EXEC → no extra beats accepted and no early out_valid.
